br_tag_alloc: RTL and testbench
===============================

// Module: br_tag_alloc
// PURPOSE
//  Branch-tag allocator and redirect front end; the counterpart of the branch execute unit.
//  Hands out circular branch tags at dispatch and frees them when branches commit.
//  Consumes the branch unit's one-hot kill vector and rolls the allocation pointer back to the
//  mispredicted branch. Registers the kill as a one-cycle flush pulse with redirect PC for fetch.
// PARAMETERS
//  WIDTH_BRM  4  tag width; N = 2**WIDTH_BRM tags, at most N-1 branches outstanding
// PORTS
//  i_clk       in   1          clock, rising edge
//  i_rst_n     in   1          asynchronous reset, active low
//  i_alloc     in   1          dispatch has a branch this cycle and requests a tag
//  o_alloc_ok  out  1          alloc granted this cycle (combinational)
//  o_brmask    out  WIDTH_BRM  current tag; every dispatched uop, including the branch, carries it
//  i_free      in   1          oldest outstanding branch committed; release its tag
//  i_brkill    in   N          kill vector from branch execute; bit t set = tag t squashed
//  i_PC        in   32         corrected PC from branch execute, valid when |i_brkill
//  o_count     out  WIDTH_BRM  outstanding branches, (tail-head) mod N
//  o_full      out  1          o_count == N-1
//  o_flush     out  1          one-cycle registered flush pulse to fetch/decode
//  o_redir_PC  out  32         redirect target, valid while o_flush
//  o_err       out  1          sticky: malformed kill vector seen
// BEHAVIOUR
//  - State: head, tail (WIDTH_BRM each, wrap mod N); o_brmask = tail; o_count = tail-head mod N.
//  - Reset (async, i_rst_n=0): head=tail=0, o_flush=0, o_redir_PC=0, o_err=0; hence o_brmask=0, o_count=0.
//  - o_alloc_ok = i_alloc & ~o_full & ~|i_brkill. Granted alloc: tail <= tail+1 at next edge.
//    The branch itself carries the pre-increment tag; younger uops carry the new one.
//  - Free: i_free & (o_count!=0) -> head <= head+1. Free while empty is ignored, no error.
//  - Kill (|i_brkill): find the lowest t with kill[t] & ~kill[(t-1) mod N]; the branch tag
//    is b = (t-1) mod N. tail <= b. Any pending alloc is dropped (o_alloc_ok already 0).
//  - Malformed kill: all N bits set, or more than one run (more than one such t). Sets o_err
//    (sticky until reset). A multi-run vector still rolls back using the lowest t. An all-ones
//    vector leaves tail unchanged.
//  - Simultaneous kill+free: both apply in the same edge (head+1, tail=b). A free cannot
//    target a killed tag because killed tags are always younger than b.
//  - Flush: o_flush <= |i_brkill; o_redir_PC <= i_PC when |i_brkill, else holds. Latency 1 cycle.
//    Back-to-back kills produce back-to-back pulses, each carrying its own PC.
//  - Wrap: all pointer arithmetic is WIDTH_BRM-bit modular. Full at N-1 keeps the tag
//    space unambiguous for kill decode.
// TESTING
//  1 Reset mid-run with tail=5, head=2 -> same cycle o_brmask=0, o_count=0, o_flush=0; o_err cleared.
//  2 W=4, 15 consecutive i_alloc -> o_brmask 0..15 then o_full=1; 16th alloc gets o_alloc_ok=0, tail stays 15.
//  3 Tail=6, head=1, i_brkill=16'h0070, i_PC=32'h0000_1040 -> tail=3, o_count=2;
//    next cycle o_flush=1, o_redir_PC=32'h0000_1040; cycle after o_flush=0.
//  4 Head=14, tail=2 (wrapped), i_brkill=16'h0003 with i_free -> head=15, tail=15, o_count=0.
//  5 Same-cycle i_alloc + kill 16'h0004 at tail=3 -> o_alloc_ok=0, tail=1; then i_free at count 0 -> no change.
//  6 i_brkill=16'h0505 -> o_err=1, tail=15 (lowest t=0, b=15); i_brkill=16'hFFFF -> tail unchanged, o_err stays 1.

Source files
------------

// File: rtl/br_tag_alloc.sv
// Branch-tag allocator: circular tag pointers for in-flight branches, kill-vector
// decode with tail rollback, and a registered flush/redirect pulse toward fetch.
module br_tag_alloc #(
   parameter int WIDTH_BRM = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_alloc,
   output logic                      o_alloc_ok,
   output logic [WIDTH_BRM-1:0]      o_brmask,
   input  logic                      i_free,
   input  logic [(2**WIDTH_BRM)-1:0] i_brkill,
   input  logic [31:0]               i_PC,
   output logic [WIDTH_BRM-1:0]      o_count,
   output logic                      o_full,
   output logic                      o_flush,
   output logic [31:0]               o_redir_PC,
   output logic                      o_err
);
   localparam int N = 2**WIDTH_BRM;

   logic [WIDTH_BRM-1:0] head_q, head_d, tail_q, tail_d;
   logic                 flush_q, flush_d, err_q, err_d;
   logic [31:0]          redir_pc_q, redir_pc_d;

   logic [N-1:0]         kill_prev, run_start;
   logic                 kill_any, kill_all, kill_multi;
   logic [WIDTH_BRM-1:0] first_t, kill_tag;

   assign o_count    = tail_q - head_q;
   assign o_full     = &o_count;
   assign o_brmask   = tail_q;
   assign o_alloc_ok = i_alloc & ~o_full & ~kill_any;
   assign o_flush    = flush_q;
   assign o_redir_PC = redir_pc_q;
   assign o_err      = err_q;

   // Kill decode: a run starts at t when kill[t] is set and kill[t-1] (mod N) is not;
   // the mispredicted branch is the tag just below the lowest run start.
   always_comb begin
      kill_prev  = {i_brkill[N-2:0], i_brkill[N-1]};
      run_start  = i_brkill & ~kill_prev;
      kill_any   = |i_brkill;
      kill_all   = &i_brkill;
      kill_multi = |(run_start & (run_start - {{(N-1){1'b0}}, 1'b1}));
      first_t    = '0;
      for (int t = N-1; t >= 0; t--) begin
         if (run_start[t]) first_t = WIDTH_BRM'(t);
      end
      kill_tag   = first_t - {{(WIDTH_BRM-1){1'b0}}, 1'b1};
   end

   // Next-state: rollback has priority over alloc; free proceeds independently.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      err_d      = err_q | (kill_any & (kill_all | kill_multi));
      flush_d    = kill_any;
      redir_pc_d = redir_pc_q;
      if (kill_any) begin
         redir_pc_d = i_PC;
         // An all-ones vector has no run start, so there is no branch to roll back to.
         if (!kill_all) tail_d = kill_tag;
      end else if (o_alloc_ok) begin
         tail_d = tail_q + 1'b1;
      end
      if (i_free && (o_count != '0)) head_d = head_q + 1'b1;
   end

   // State registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         flush_q    <= 1'b0;
         redir_pc_q <= '0;
         err_q      <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         flush_q    <= flush_d;
         redir_pc_q <= redir_pc_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_br_tag_alloc.sv
module tb_br_tag_alloc;
   localparam int W = 4;
   localparam int N = 2**W;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_alloc = 1'b0;
   logic          i_free = 1'b0;
   logic [N-1:0]  i_brkill = '0;
   logic [31:0]   i_PC = '0;
   logic          o_alloc_ok, o_full, o_flush, o_err;
   logic [W-1:0]  o_brmask, o_count;
   logic [31:0]   o_redir_PC;

   int total = 0;
   int bad = 0;

   // reference model: queue of outstanding tags in age order, next tag to hand out
   int          q[$];
   int          nt;
   bit          m_err, m_flush;
   logic [31:0] m_pc;

   br_tag_alloc #(.WIDTH_BRM(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_alloc(i_alloc), .o_alloc_ok(o_alloc_ok),
      .o_brmask(o_brmask), .i_free(i_free), .i_brkill(i_brkill), .i_PC(i_PC),
      .o_count(o_count), .o_full(o_full), .o_flush(o_flush), .o_redir_PC(o_redir_PC),
      .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      nt = 0;
      m_err = 0;
      m_flush = 0;
      m_pc = '0;
   endtask

   task automatic check_all(input string tag, input bit exp_ok);
      chk({tag, ":alloc_ok"}, 32'(o_alloc_ok), 32'(exp_ok));
      chk({tag, ":brmask"},   32'(o_brmask),   32'(nt));
      chk({tag, ":count"},    32'(o_count),    32'(q.size()));
      chk({tag, ":full"},     32'(o_full),     32'(q.size() == N-1));
      chk({tag, ":flush"},    32'(o_flush),    32'(m_flush));
      chk({tag, ":redir"},    o_redir_PC,      m_pc);
      chk({tag, ":err"},      32'(o_err),      32'(m_err));
   endtask

   // one clock: drive, check pre-edge view, then advance model across the edge
   task automatic cyc(input string tag, input bit a, input bit f,
                      input logic [N-1:0] k, input logic [31:0] pc);
      bit ok;
      int sz0, t_low, runs, b, h0, ns;
      i_alloc = a; i_free = f; i_brkill = k; i_PC = pc;
      #1;
      ok = a && (q.size() < N-1) && (k == '0);
      check_all(tag, ok);
      @(posedge i_clk);
      sz0 = q.size();
      if (k != '0) begin
         t_low = -1; runs = 0;
         for (int t = 0; t < N; t++)
            if (k[t] && !k[(t+N-1)%N]) begin
               runs++;
               if (t_low < 0) t_low = t;
            end
         if (runs != 1) m_err = 1;
         if (runs > 0) begin
            b  = (t_low + N - 1) % N;
            h0 = (sz0 != 0) ? q[0] : nt;
            ns = (b - h0 + N) % N;
            q.delete();
            for (int i = 0; i < ns; i++) q.push_back((h0 + i) % N);
            nt = b;
         end
         m_pc = pc;
      end else if (ok) begin
         q.push_back(nt);
         nt = (nt + 1) % N;
      end
      if (f && sz0 != 0) void'(q.pop_front());
      m_flush = (k != '0);
      #1;
   endtask

   task automatic do_reset(input string tag);
      i_rst_n = 1'b0;
      i_alloc = 0; i_free = 0; i_brkill = '0;
      #2;
      model_reset();
      check_all(tag, 1'b0);
      i_rst_n = 1'b1;
   endtask

   initial begin
      logic [N-1:0] kv;
      int kidx, b, len;
      bit a, f;
      model_reset();
      #3;
      do_reset("por");
      @(posedge i_clk); #1;

      // fill to full, then one refused alloc
      for (int i = 0; i < 15; i++) cyc("fill", 1, 0, '0, 0);
      chk("full_tag", 32'(o_brmask), 32'd15);
      chk("full_flag", 32'(o_full), 32'd1);
      cyc("alloc_full", 1, 0, '0, 0);
      chk("tail_hold", 32'(o_brmask), 32'd15);
      for (int i = 0; i < 16; i++) cyc("drain", 0, 1, '0, 0);

      // tail=6 head=1 rollback on 0x0070
      do_reset("rst3");
      for (int i = 0; i < 6; i++) cyc("t3a", 1, 0, '0, 0);
      cyc("t3f", 0, 1, '0, 0);
      cyc("t3k", 0, 0, 16'h0070, 32'h0000_1040);
      chk("t3_tail", 32'(o_brmask), 32'd3);
      chk("t3_cnt", 32'(o_count), 32'd2);
      chk("t3_flush", 32'(o_flush), 32'd1);
      chk("t3_pc", o_redir_PC, 32'h0000_1040);
      cyc("t3n", 0, 0, '0, 0);
      chk("t3_flush_off", 32'(o_flush), 32'd0);

      // wrapped pointers, kill with simultaneous free
      do_reset("rst4");
      for (int i = 0; i < 14; i++) cyc("t4a", 1, 0, '0, 0);
      for (int i = 0; i < 14; i++) cyc("t4f", 0, 1, '0, 0);
      for (int i = 0; i < 4; i++) cyc("t4b", 1, 0, '0, 0);
      cyc("t4k", 0, 1, 16'h0003, 32'h0000_2000);
      chk("t4_tail", 32'(o_brmask), 32'd15);
      chk("t4_cnt", 32'(o_count), 32'd0);

      // alloc colliding with kill, then frees past empty
      do_reset("rst5");
      for (int i = 0; i < 3; i++) cyc("t5a", 1, 0, '0, 0);
      cyc("t5k", 1, 0, 16'h0004, 32'h0000_3000);
      chk("t5_tail", 32'(o_brmask), 32'd1);
      cyc("t5f", 0, 1, '0, 0);
      cyc("t5f0", 0, 1, '0, 0);

      // malformed kill vectors
      cyc("t6m", 0, 0, 16'h0505, 32'h0000_4000);
      chk("t6_err", 32'(o_err), 32'd1);
      chk("t6_tail", 32'(o_brmask), 32'd15);
      cyc("t6a", 0, 0, 16'hFFFF, 32'h0000_5000);
      chk("t6_tail_hold", 32'(o_brmask), 32'd15);
      chk("t6_err_hold", 32'(o_err), 32'd1);

      // reset mid-run at tail=5 head=2 with err set
      cyc("t1k", 0, 0, 16'h0040, 32'h0000_6000);
      cyc("t1f", 0, 1, '0, 0);
      chk("t1_tail", 32'(o_brmask), 32'd5);
      chk("t1_cnt", 32'(o_count), 32'd4 - 32'd1);
      do_reset("t1_rst");

      // randomized legal traffic
      @(posedge i_clk); #1;
      for (int n = 0; n < 600; n++) begin
         a = 1'($urandom_range(0, 99) < 60);
         f = 1'($urandom_range(0, 99) < 35);
         kv = '0;
         if (q.size() > 0 && $urandom_range(0, 99) < 8) begin
            kidx = $urandom_range(0, q.size() - 1);
            b = q[kidx];
            len = $urandom_range(1, N - 2);
            for (int j = 1; j <= len; j++) kv[(b + j) % N] = 1'b1;
            if (kidx == 0) f = 0;
         end
         cyc("rnd", a, f, kv, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
